// File: rtl/ahfp_pkg.sv
// Shared definitions for the AHFP arithmetic blocks: rounding-mode codes,
// operand classes and the exponent bias helper.
package ahfp_pkg;

  typedef logic [1:0] round_mode_t;

  localparam round_mode_t MODE_FLOOR = 2'b00;
  localparam round_mode_t MODE_CEIL  = 2'b01;
  localparam round_mode_t MODE_TRUNC = 2'b10;
  localparam round_mode_t MODE_RNE   = 2'b11;

  // ZERO: +/-0, NORM: has fraction bits to round, INTEGRAL: no fraction bits,
  // SUB1: 0 < |x| < 1 (denormals included), INF, NAN.
  typedef enum logic [2:0] {
    CLS_ZERO,
    CLS_NORM,
    CLS_INTEGRAL,
    CLS_SUB1,
    CLS_INF,
    CLS_NAN
  } fp_class_e;

  // Exponent bias of an IEEE-style format with exp_w exponent bits.
  function automatic int unsigned bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/ahfp_round_decide.sv
// Round-up decision from mode, sign and the guard/sticky/lsb summary of the
// discarded fraction. Purely combinational.
module ahfp_round_decide
  import ahfp_pkg::*;
(
  input  round_mode_t mode,
  input  logic        sign,
  input  logic        frac_nz,
  input  logic        guard,
  input  logic        sticky,
  input  logic        lsb,
  output logic        round_up
);

  // Magnitude increment needed to reach the rounded integral value.
  always_comb begin
    // NOTE: the default keeps round_up assigned on every path, so no latch is inferred.
    round_up = 1'b0;
    unique case (mode)
      MODE_FLOOR: round_up = sign & frac_nz;
      MODE_CEIL:  round_up = ~sign & frac_nz;
      MODE_TRUNC: round_up = 1'b0;
      MODE_RNE:   round_up = guard & (sticky | lsb);
      default:    round_up = 1'b0;
    endcase
  end

endmodule

// File: rtl/ahfp_round_pipe.sv
// Pipelined floating-point round-to-integral unit with valid/ready flow
// control. S1 classifies and builds the fraction mask, S2 applies the mask and
// decides rounding, S3 increments and registers the result and flags.
module ahfp_round_pipe
  import ahfp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_data,
  input  logic [1:0]           in_mode,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_inexact,
  output logic                 out_nan
);

  localparam int unsigned      BIAS      = bias(EXP_W);
  localparam int unsigned      INT_LIM   = BIAS + MAN_W;
  localparam logic [EXP_W-1:0] EXP_MAX   = '1;
  localparam logic [EXP_W-1:0] EXP_ZERO  = '0;
  localparam logic [EXP_W-1:0] EXP_ONE   = EXP_W'(BIAS);
  localparam logic [EXP_W-1:0] EXP_HALF  = EXP_W'(BIAS - 1);
  localparam logic [EXP_W-1:0] EXP_INC   = EXP_W'(1);
  localparam logic [MAN_W-1:0] MAN_ZERO  = '0;
  localparam logic [MAN_W-1:0] MAN_ALL   = '1;
  localparam logic [MAN_W-1:0] MAN_QUIET = {1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [MAN_W:0]   POS_ONE   = {{MAN_W{1'b0}}, 1'b1};

  // All stages move together; a stalled S3 freezes the whole pipe.
  logic advance;
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // ---------------- S1: classify, unbiased exponent, fraction mask ----------
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_man;
  logic [31:0]      exp_u;
  logic [31:0]      frac_bits;
  fp_class_e        cls_c;
  logic [MAN_W-1:0] mask_c;

  assign {in_sign, in_exp, in_man} = in_data;
  assign exp_u     = 32'(in_exp);
  assign frac_bits = INT_LIM - exp_u;

  // Class of the incoming operand and, for NORM, the mask of MAN_W-e fraction bits.
  always_comb begin
    cls_c  = CLS_NORM;
    mask_c = MAN_ZERO;
    if (in_exp == EXP_MAX)                   cls_c = (|in_man) ? CLS_NAN : CLS_INF;
    else if (in_exp == EXP_ZERO && !(|in_man)) cls_c = CLS_ZERO;
    else if (exp_u < BIAS)                   cls_c = CLS_SUB1;
    else if (exp_u >= INT_LIM)               cls_c = CLS_INTEGRAL;
    else                                     mask_c = ~(MAN_ALL << frac_bits);
  end

  logic             s1_valid;
  logic             s1_sign;
  logic [EXP_W-1:0] s1_exp;
  logic [MAN_W-1:0] s1_man;
  logic [MAN_W-1:0] s1_mask;
  logic             s1_half;
  round_mode_t      s1_mode;
  logic [TAG_W-1:0] s1_tag;
  fp_class_e        s1_cls;

  // ---------------- S2: apply mask, guard/sticky, round decision ------------
  logic [MAN_W-1:0] frac_c;
  logic [MAN_W-1:0] kept_c;
  logic [MAN_W:0]   pos_c;
  logic             dec_frac_nz;
  logic             dec_guard;
  logic             dec_sticky;
  logic             dec_lsb;
  logic             dec_up;

  assign frac_c = s1_man & s1_mask;
  assign kept_c = s1_man & ~s1_mask;
  assign pos_c  = {1'b0, s1_mask} + POS_ONE;

  // Summaries of the discarded fraction; |x|<1 maps onto the same decision
  // with the hidden one as guard when e = -1.
  always_comb begin
    dec_frac_nz = |frac_c;
    dec_guard   = |(s1_man & s1_mask & ~(s1_mask >> 1));
    dec_sticky  = |(s1_man & (s1_mask >> 1));
    dec_lsb     = |({1'b1, s1_man} & pos_c);
    if (s1_cls == CLS_SUB1) begin
      dec_frac_nz = 1'b1;
      dec_guard   = s1_half;
      dec_sticky  = |s1_man;
      dec_lsb     = 1'b0;
    end
  end

  ahfp_round_decide u_decide (
    .mode     (s1_mode),
    .sign     (s1_sign),
    .frac_nz  (dec_frac_nz),
    .guard    (dec_guard),
    .sticky   (dec_sticky),
    .lsb      (dec_lsb),
    .round_up (dec_up)
  );

  logic             s2_valid;
  logic             s2_sign;
  logic [EXP_W-1:0] s2_exp;
  logic [MAN_W-1:0] s2_man;
  logic [MAN_W:0]   s2_pos;
  logic             s2_up;
  logic             s2_inexact;
  logic [TAG_W-1:0] s2_tag;
  fp_class_e        s2_cls;

  // ---------------- S3: increment, exponent carry, result select ------------
  logic [MAN_W:0]       sum_c;
  logic [EXP_W+MAN_W:0] res_c;

  assign sum_c = {1'b1, s2_man} + s2_pos;

  // Final value per class; losing the hidden one in sum_c means the
  // significand carried into the next binade.
  always_comb begin
    res_c = {s2_sign, s2_exp, s2_man};
    unique case (s2_cls)
      CLS_NAN:  res_c = {s2_sign, s2_exp, s2_man | MAN_QUIET};
      CLS_SUB1: res_c = s2_up ? {s2_sign, EXP_ONE, MAN_ZERO} : {s2_sign, EXP_ZERO, MAN_ZERO};
      CLS_NORM: begin
        if (s2_up) begin
          if (!sum_c[MAN_W]) res_c = {s2_sign, s2_exp + EXP_INC, MAN_ZERO};
          else               res_c = {s2_sign, s2_exp, sum_c[MAN_W-1:0]};
        end
      end
      default:  res_c = {s2_sign, s2_exp, s2_man};
    endcase
  end

  // Stage valids and the output registers; these are the only state that must
  // come out of reset clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_tag     <= '0;
      out_inexact <= 1'b0;
      out_nan     <= 1'b0;
    end else if (advance) begin
      // NOTE: non-blocking assignments let every stage read its predecessor's old value on the same edge.
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data    <= res_c;
        out_tag     <= s2_tag;
        out_inexact <= s2_inexact;
        out_nan     <= (s2_cls == CLS_NAN);
      end
    end
  end

  // Stage payloads, loaded only alongside a valid operand.
  // NOTE: payload registers are deliberately not reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      s1_sign <= in_sign;
      s1_exp  <= in_exp;
      s1_man  <= in_man;
      s1_mask <= mask_c;
      s1_half <= (in_exp == EXP_HALF);
      s1_mode <= in_mode;
      s1_tag  <= in_tag;
      s1_cls  <= cls_c;
    end
    if (advance && s1_valid) begin
      s2_sign    <= s1_sign;
      s2_exp     <= s1_exp;
      s2_man     <= (s1_cls == CLS_NORM) ? kept_c : s1_man;
      s2_pos     <= pos_c;
      s2_up      <= dec_up & ((s1_cls == CLS_NORM) | (s1_cls == CLS_SUB1));
      s2_inexact <= ((s1_cls == CLS_NORM) & (|frac_c)) | (s1_cls == CLS_SUB1);
      s2_tag     <= s1_tag;
      s2_cls     <= s1_cls;
    end
  end

endmodule

// File: tb/tb_ahfp_round_pipe.sv
// Self-checking bench for ahfp_round_pipe (8/23 format): integer-arithmetic
// reference model, directed vectors, backpressure, mid-stream reset and
// randomized traffic with random output stalls.
module tb_ahfp_round_pipe;

  localparam int EW   = 8;
  localparam int MW   = 23;
  localparam int TW   = 4;
  localparam int W    = 1 + EW + MW;
  localparam int BIAS = 127;
  localparam int EMAX = 255;

  localparam logic [1:0] M_FLOOR = 2'd0;
  localparam logic [1:0] M_CEIL  = 2'd1;
  localparam logic [1:0] M_TRUNC = 2'd2;
  localparam logic [1:0] M_RNE   = 2'd3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [1:0]    in_mode = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;
  logic          out_inexact;
  logic          out_nan;

  ahfp_round_pipe #(.EXP_W(EW), .MAN_W(MW), .TAG_W(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_mode     (in_mode),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_tag     (out_tag),
    .out_inexact (out_inexact),
    .out_nan     (out_nan)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic [TW-1:0] tag;
    logic          inx;
    logic          nan;
    int            acc;
    bit            seen;
  } exp_t;

  exp_t         q[$];
  exp_t         ent;
  int           n_checks = 0;
  int           n_errors = 0;
  int           cyc = 0;
  bit           lat_mode = 1'b0;
  logic [W-1:0] dir_x[$];
  logic [1:0]   dir_m[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Round-to-integral computed on the value sig * 2^(e-MW) with plain integers.
  function automatic void model(input logic [W-1:0] x, input logic [1:0] mode,
                                output logic [W-1:0] r, output logic inx, output logic nan);
    logic s;
    int ex, e, k;
    longint unsigned m, sig, ip, fr, half, res;
    bit up;
    s   = x[W-1];
    ex  = int'(x[W-2:MW]);
    m   = 64'(x[MW-1:0]);
    r   = x;
    inx = 1'b0;
    nan = 1'b0;
    up  = 1'b0;
    e   = ex - BIAS;
    if (ex == EMAX) begin
      if (m != 0) begin
        nan = 1'b1;
        r[MW-1] = 1'b1;
      end
      return;
    end
    if (ex == 0 && m == 0) return;
    if (e >= MW) return;
    if (e < 0) begin
      inx = 1'b1;
      case (mode)
        M_FLOOR: up = s;
        M_CEIL:  up = !s;
        M_TRUNC: up = 1'b0;
        default: up = (ex == BIAS - 1) && (m != 0);
      endcase
      r = up ? {s, EW'(BIAS), {MW{1'b0}}} : {s, {(W-1){1'b0}}};
      return;
    end
    k    = MW - e;
    sig  = (64'd1 << MW) | m;
    ip   = sig >> k;
    fr   = sig & ((64'd1 << k) - 64'd1);
    half = 64'd1 << (k - 1);
    inx  = (fr != 0);
    case (mode)
      M_FLOOR: up = s && (fr != 0);
      M_CEIL:  up = !s && (fr != 0);
      M_TRUNC: up = 1'b0;
      default: up = (fr > half) || (fr == half && ip[0]);
    endcase
    res = (ip + 64'(up)) << k;
    if (res >= (64'd1 << (MW + 1))) begin
      ex  = ex + 1;
      res = res >> 1;
    end
    r = {s, ex[EW-1:0], res[MW-1:0]};
  endfunction

  // Single compare process: checks outputs against the model queue each
  // cycle, then books the transfers that the coming rising edge will perform.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", out_valid, 1'b0);
        end else begin
          check("out_data", out_data, q[0].data);
          check("out_tag", out_tag, q[0].tag);
          check("out_inexact", out_inexact, q[0].inx);
          check("out_nan", out_nan, q[0].nan);
          if (lat_mode && !q[0].seen) check("latency", cyc - q[0].acc, 3);
          q[0].seen = 1'b1;
          if (out_ready) void'(q.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        model(in_data, in_mode, ent.data, ent.inx, ent.nan);
        ent.tag  = in_tag;
        ent.acc  = cyc;
        ent.seen = 1'b0;
        q.push_back(ent);
      end
    end
    cyc++;
  end

  // Present one operand and hold it until the accepting edge.
  task automatic send(input logic [W-1:0] x, input logic [1:0] m, input logic [TW-1:0] t);
    in_valid = 1'b1;
    in_data  = x;
    in_mode  = m;
    in_tag   = t;
    for (int n = 0; n < 500; n++) begin
      @(posedge clk);
      if (in_ready) begin
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    n_checks++;
    n_errors++;
    $display("FAIL send_timeout: in_ready stayed 0 for 500 cycles, data %h", x);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_empty", q.size(), 0);
    @(posedge clk);
    #1;
    check("drain_out_valid", out_valid, 1'b0);
  endtask

  // Pins the model to hand-computed values and queues the vector for the DUT.
  task automatic pin(input logic [W-1:0] x, input logic [1:0] m, input logic [W-1:0] want,
                     input logic want_inx, input logic want_nan);
    logic [W-1:0] r;
    logic inx, nan;
    model(x, m, r, inx, nan);
    check("pin_data", r, want);
    check("pin_inexact", inx, want_inx);
    check("pin_nan", nan, want_nan);
    dir_x.push_back(x);
    dir_m.push_back(m);
  endtask

  function automatic logic [W-1:0] rand_op();
    logic [EW-1:0] ex;
    logic [MW-1:0] m;
    int sel, sh;
    sel = $urandom_range(0, 9);
    m   = MW'($urandom);
    case (sel)
      0:       ex = '0;
      1:       ex = '1;
      2:       ex = EW'(BIAS - 1);
      default: ex = EW'($urandom_range(118, 155));
    endcase
    if ($urandom_range(0, 2) == 0) begin
      sh = $urandom_range(0, MW);
      m  = (m >> sh) << sh;
    end
    if ($urandom_range(0, 7) == 0) m = '0;
    return {1'($urandom), ex, m};
  endfunction

  bit rnd_done = 1'b0;

  initial begin
    // Model pins from hand-worked values.
    pin(32'h4015FC65, M_FLOOR, 32'h40000000, 1'b1, 1'b0);
    pin(32'h42FF999A, M_FLOOR, 32'h42FE0000, 1'b1, 1'b0);
    pin(32'hBF000000, M_FLOOR, 32'hBF800000, 1'b1, 1'b0);
    pin(32'h3DCCCCCD, M_FLOOR, 32'h00000000, 1'b1, 1'b0);
    pin(32'h4015FC65, M_CEIL,  32'h40400000, 1'b1, 1'b0);
    pin(32'h42FF999A, M_CEIL,  32'h43000000, 1'b1, 1'b0);
    pin(32'hBF000000, M_CEIL,  32'h80000000, 1'b1, 1'b0);
    pin(32'h5306BBF0, M_CEIL,  32'h5306BBF0, 1'b0, 1'b0);
    pin(32'h40200000, M_RNE,   32'h40000000, 1'b1, 1'b0);
    pin(32'h40600000, M_RNE,   32'h40800000, 1'b1, 1'b0);
    pin(32'h3F000000, M_RNE,   32'h00000000, 1'b1, 1'b0);
    pin(32'h3F0F5C29, M_RNE,   32'h3F800000, 1'b1, 1'b0);
    pin(32'hC015FC65, M_TRUNC, 32'hC0000000, 1'b1, 1'b0);
    pin(32'h7FA00000, M_FLOOR, 32'h7FE00000, 1'b0, 1'b1);
    pin(32'hFF800000, M_CEIL,  32'hFF800000, 1'b0, 1'b0);
    pin(32'h80000000, M_FLOOR, 32'h80000000, 1'b0, 1'b0);
    pin(32'h80000001, M_FLOOR, 32'hBF800000, 1'b1, 1'b0);
    pin(32'h40400000, M_RNE,   32'h40400000, 1'b0, 1'b0);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_flags", {out_inexact, out_nan}, 2'b00);
    check("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors back-to-back, no backpressure, exact latency.
    lat_mode = 1'b1;
    for (int i = 0; i < dir_x.size(); i++) send(dir_x[i], dir_m[i], TW'(i));
    drain();
    lat_mode = 1'b0;

    // Backpressure: out_ready low for cycles 4..7 of a 5-operand burst.
    fork
      begin
        for (int i = 0; i < 5; i++) send(dir_x[i], M_FLOOR, TW'(i));
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
          @(negedge clk);
          check("bp_out_valid", out_valid, 1'b1);
          check("bp_in_ready", in_ready, 1'b0);
          check("bp_held_tag", out_tag, 1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with operands in flight.
    send(32'h42FF999A, M_FLOOR, 4'd5);
    send(32'h4015FC65, M_CEIL,  4'd6);
    send(32'hBF000000, M_FLOOR, 4'd7);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_tag", out_tag, 0);
    check("mid_rst_flags", {out_inexact, out_nan}, 2'b00);
    check("mid_rst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_quiet", out_valid, 1'b0);
    lat_mode = 1'b1;
    send(32'h4015FC65, M_CEIL, 4'd9);
    drain();
    lat_mode = 1'b0;

    // Randomized traffic with random gaps and random output stalls.
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(rand_op(), 2'($urandom), TW'(i));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
